// File: rtl/tmr0_ng.sv
// Purpose : TMR0-style timer/counter: core-clock or synchronised external count, optional
//           2**(ps+1) prescaler, software load with 2-edge increment inhibit, sticky wrap flag.
// Latency : internal count updates tmr0out on the sampling edge; an external transition
//           stable before edge k reaches tmr0out at edge k+2. Outputs are registered.
// Backpressure: none. Events that arrive while disabled, while inhibited after a load,
//           or on a prescaler-clearing edge are dropped, not queued.
//
// Ports:
//   oscIn    in   core clock, all state changes on its rising edge
//   reset    in   asynchronous active-low reset
//   t0cki    in   external count input (asynchronous to oscIn)
//   t0cs     in   source select: 0 = every oscIn cycle, 1 = t0cki edge
//   t0se     in   external edge select: 0 = rising, 1 = falling
//   psa      in   1 = prescaler bypassed, 0 = prescaler in the count path
//   ps       in   prescale select, ratio = 2**(ps+1)
//   tmr_en   in   1 = count; 0 = timer, prescaler and inhibit counter frozen
//   wr_en    in   load strobe
//   wr_data  in   load value
//   t0if_clr in   clears the overflow flag
//   tmr0out  out  timer value
//   t0if     out  sticky overflow flag
module tmr0_ng #(
    parameter int WIDTH   = 8,   // 8 or 16
    parameter int PS_BITS = 3
) (
    input  logic               oscIn,
    input  logic               reset,
    input  logic               t0cki,
    input  logic               t0cs,
    input  logic               t0se,
    input  logic               psa,
    input  logic [PS_BITS-1:0] ps,
    input  logic               tmr_en,
    input  logic               wr_en,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic               t0if_clr,
    output logic [WIDTH-1:0]   tmr0out,
    output logic               t0if
);

    // The largest ratio 2**(2**PS_BITS) needs a 2**PS_BITS-bit prescaler counter.
    localparam int PSC_W = 1 << PS_BITS;

    // ---------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------
    logic               r_s1;       // first synchroniser stage
    logic               r_s2;       // second synchroniser stage (metastability-safe)
    logic               r_s3;       // history of r_s2 for edge detection
    logic [PS_BITS-1:0] r_ps_sh;    // shadow of ps, to detect a reconfiguration
    logic               r_psa_sh;   // shadow of psa
    logic [PSC_W-1:0]   r_psc;      // prescaler event counter
    logic [1:0]         r_inh;      // increment inhibit after a load
    logic [WIDTH-1:0]   r_tmr;
    logic               r_t0if;

    // ---------------------------------------------------------------
    // Combinational decode
    // ---------------------------------------------------------------
    logic               w_ext_evt;
    logic               w_evt;
    logic               w_accept;
    logic               w_cfg_chg;
    logic               w_ps_clr;
    logic [PSC_W-1:0]   w_ps_max;
    logic               w_ps_term;
    logic               w_inc;
    logic               w_wrap;

    // Edge seen on the synchronised pin; r_s2 is already safe to use directly.
    assign w_ext_evt = t0se ? (~r_s2 & r_s3) : (r_s2 & ~r_s3);

    // Internal source produces one event per core clock.
    assign w_evt = t0cs ? w_ext_evt : 1'b1;

    // An event only counts when enabled and not inside the post-load window.
    assign w_accept = w_evt & tmr_en & (r_inh == 2'd0);

    // Any change of prescaler configuration restarts the prescaler so the next
    // terminal count is a full period of the new ratio.
    assign w_cfg_chg = (ps != r_ps_sh) | (psa != r_psa_sh);
    assign w_ps_clr  = wr_en | w_cfg_chg;

    // Terminal value R-1 = 2**(ps+1)-1: bits 0..ps set, the rest clear.
    always_comb begin
        w_ps_max = '0;
        for (int i = 0; i < PSC_W; i++) begin
            w_ps_max[i] = (PS_BITS'(i) <= ps);
        end
    end

    assign w_ps_term = (r_psc == w_ps_max);

    // A clearing edge wins over the prescaler: the event on that edge is dropped
    // and never produces a timer increment through the prescaler path.
    assign w_inc = w_accept & (psa | (~w_ps_clr & w_ps_term));

    // A load has priority over an increment, so a load can never cause a wrap.
    assign w_wrap = w_inc & ~wr_en & (r_tmr == {WIDTH{1'b1}});

    // ---------------------------------------------------------------
    // External input synchroniser; runs regardless of tmr_en so that the
    // edge detector never sees a stale level when counting is resumed.
    // ---------------------------------------------------------------
    always_ff @(posedge oscIn or negedge reset) begin
        if (!reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= t0cki;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // ---------------------------------------------------------------
    // Configuration shadow
    // ---------------------------------------------------------------
    always_ff @(posedge oscIn or negedge reset) begin
        if (!reset) begin
            r_ps_sh  <= '0;
            r_psa_sh <= 1'b0;
        end else begin
            r_ps_sh  <= ps;
            r_psa_sh <= psa;
        end
    end

    // ---------------------------------------------------------------
    // Prescaler: only advances on accepted events while assigned.
    // ---------------------------------------------------------------
    always_ff @(posedge oscIn or negedge reset) begin
        if (!reset) begin
            r_psc <= '0;
        end else if (w_ps_clr) begin
            r_psc <= '0;
        end else if (w_accept && !psa) begin
            r_psc <= w_ps_term ? '0 : r_psc + PSC_W'(1);
        end
    end

    // ---------------------------------------------------------------
    // Inhibit counter: loaded with 2 on a write so edges w+1 and w+2 drop
    // their events. Holds while tmr_en=0, so the window is measured in
    // enabled cycles.
    // ---------------------------------------------------------------
    always_ff @(posedge oscIn or negedge reset) begin
        if (!reset) begin
            r_inh <= 2'd0;
        end else if (wr_en) begin
            r_inh <= 2'd2;
        end else if (tmr_en && (r_inh != 2'd0)) begin
            r_inh <= r_inh - 2'd1;
        end
    end

    // ---------------------------------------------------------------
    // Timer register
    // ---------------------------------------------------------------
    always_ff @(posedge oscIn or negedge reset) begin
        if (!reset) begin
            r_tmr <= '0;
        end else if (wr_en) begin
            r_tmr <= wr_data;
        end else if (w_inc) begin
            r_tmr <= r_tmr + WIDTH'(1);
        end
    end

    // ---------------------------------------------------------------
    // Overflow flag: a wrap on the same edge as a clear leaves it set, so
    // software cannot lose an overflow that races its own acknowledge.
    // ---------------------------------------------------------------
    always_ff @(posedge oscIn or negedge reset) begin
        if (!reset) begin
            r_t0if <= 1'b0;
        end else if (w_wrap) begin
            r_t0if <= 1'b1;
        end else if (t0if_clr) begin
            r_t0if <= 1'b0;
        end
    end

    assign tmr0out = r_tmr;
    assign t0if    = r_t0if;

endmodule

// File: tb/tb_tmr0_ng.sv
// Purpose : directed bench for tmr0_ng (8-bit and 16-bit instances side by side).
// Latency : inputs driven 1 time unit after each rising edge, outputs sampled at the same point.
// Backpressure: n/a.
module tb_tmr0_ng;

    logic        oscIn = 1'b0;
    logic        reset = 1'b0;
    logic        t0cki = 1'b0;
    logic        t0cs  = 1'b0;
    logic        t0se  = 1'b0;
    logic        psa   = 1'b1;
    logic [2:0]  ps    = 3'd0;
    logic        tmr_en = 1'b0;
    logic        wr_en  = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic        wr_en16 = 1'b0;
    logic [15:0] wr_data16 = 16'h0000;
    logic        t0if_clr = 1'b0;

    logic [7:0]  tmr8;
    logic        if8;
    logic [15:0] tmr16;
    logic        if16;

    int n_checks = 0;
    int n_errors = 0;

    always #5 oscIn = ~oscIn;

    tmr0_ng #(.WIDTH(8), .PS_BITS(3)) u_dut8 (
        .oscIn    (oscIn),
        .reset    (reset),
        .t0cki    (t0cki),
        .t0cs     (t0cs),
        .t0se     (t0se),
        .psa      (psa),
        .ps       (ps),
        .tmr_en   (tmr_en),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .t0if_clr (t0if_clr),
        .tmr0out  (tmr8),
        .t0if     (if8)
    );

    tmr0_ng #(.WIDTH(16), .PS_BITS(3)) u_dut16 (
        .oscIn    (oscIn),
        .reset    (reset),
        .t0cki    (t0cki),
        .t0cs     (t0cs),
        .t0se     (t0se),
        .psa      (psa),
        .ps       (ps),
        .tmr_en   (tmr_en),
        .wr_en    (wr_en16),
        .wr_data  (wr_data16),
        .t0if_clr (t0if_clr),
        .tmr0out  (tmr16),
        .t0if     (if16)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1 unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge oscIn);
        #1;
    endtask

    task automatic write8(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        step(1);
        wr_en   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        #1;
        chk("rst_tmr", 32'(tmr8), 32'h00);
        chk("rst_if",  32'(if8),  32'h0);
        #2;
        reset = 1'b1;
        step(1);

        // ---------------- internal prescaled, R=4 ----------------
        t0cs = 1'b0; psa = 1'b0; ps = 3'd1; tmr_en = 1'b0;
        step(2);                          // let the config shadow settle while frozen
        tmr_en = 1'b1;
        step(4);
        chk("ps4_e4", 32'(tmr8), 32'h01);
        step(3);
        chk("ps4_e7", 32'(tmr8), 32'h01);
        step(1);
        chk("ps4_e8", 32'(tmr8), 32'h02);
        step(1015);
        chk("ps4_e1023_tmr", 32'(tmr8), 32'hFF);
        chk("ps4_e1023_if",  32'(if8),  32'h0);
        step(1);
        chk("ps4_e1024_tmr", 32'(tmr8), 32'h00);
        chk("ps4_e1024_if",  32'(if8),  32'h1);

        // ---------------- enable hold preserves prescaler ----------------
        step(2);                          // prescaler now holds 2
        tmr_en = 1'b0;
        step(10);
        chk("hold_tmr", 32'(tmr8), 32'h00);
        tmr_en = 1'b1;
        step(1);
        chk("hold_res1", 32'(tmr8), 32'h00);
        step(1);
        chk("hold_res2", 32'(tmr8), 32'h01);

        // ---------------- ps change restarts prescaler ----------------
        step(2);                          // prescaler at 2
        ps = 3'd0;                        // R=2
        step(1);
        chk("psch_c0", 32'(tmr8), 32'h01);
        step(1);
        chk("psch_c1", 32'(tmr8), 32'h01);
        step(1);
        chk("psch_c2", 32'(tmr8), 32'h02);

        // ---------------- flag clear alone ----------------
        t0if_clr = 1'b1;
        step(1);
        t0if_clr = 1'b0;
        chk("clr_alone", 32'(if8), 32'h0);

        // ---------------- write inhibit, psa=1 ----------------
        psa = 1'b1;
        write8(8'hFE);
        chk("wr_w",  32'(tmr8), 32'hFE);
        step(1);
        chk("wr_w1", 32'(tmr8), 32'hFE);
        step(1);
        chk("wr_w2", 32'(tmr8), 32'hFE);
        step(1);
        chk("wr_w3", 32'(tmr8), 32'hFF);
        chk("wr_w3_if", 32'(if8), 32'h0);
        step(1);
        chk("wr_w4", 32'(tmr8), 32'h00);
        chk("wr_w4_if", 32'(if8), 32'h1);

        // ---------------- set and clear on the same edge ----------------
        t0if_clr = 1'b1;
        step(1);
        t0if_clr = 1'b0;
        chk("clr2", 32'(if8), 32'h0);
        write8(8'hFF);
        step(2);
        t0if_clr = 1'b1;
        step(1);
        t0if_clr = 1'b0;
        chk("race_tmr", 32'(tmr8), 32'h00);
        chk("race_if",  32'(if8),  32'h1);

        // ---------------- write of all-ones over a pending wrap ----------------
        t0if_clr = 1'b1;
        step(1);
        t0if_clr = 1'b0;
        write8(8'hFD);
        step(3);
        chk("ovw_fe", 32'(tmr8), 32'hFE);
        step(1);
        chk("ovw_ff", 32'(tmr8), 32'hFF);
        write8(8'hFF);
        chk("ovw_tmr", 32'(tmr8), 32'hFF);
        chk("ovw_if",  32'(if8),  32'h0);
        step(3);
        chk("ovw_wrap", 32'(tmr8), 32'h00);
        chk("ovw_wrap_if", 32'(if8), 32'h1);

        // ---------------- asynchronous reset mid-count ----------------
        write8(8'h37);
        chk("pre_rst_tmr", 32'(tmr8), 32'h37);
        chk("pre_rst_if",  32'(if8),  32'h1);
        #2;
        reset = 1'b0;
        #1;                               // still well before the next edge
        chk("arst_tmr", 32'(tmr8), 32'h00);
        chk("arst_if",  32'(if8),  32'h0);
        step(2);
        chk("arst_hold_tmr", 32'(tmr8), 32'h00);
        chk("arst_hold_if",  32'(if8),  32'h0);
        reset = 1'b1;

        // ---------------- external rising edges ----------------
        t0cs = 1'b1; t0se = 1'b0; psa = 1'b1; t0cki = 1'b0;
        write8(8'h00);
        step(3);
        for (int i = 0; i < 5; i++) begin
            t0cki = 1'b1;
            step(1);
            chk("xr_k",   32'(tmr8), 32'(i));
            step(1);
            chk("xr_k1",  32'(tmr8), 32'(i));
            step(1);
            chk("xr_k2",  32'(tmr8), 32'(i + 1));
            t0cki = 1'b0;
            step(3);
            chk("xr_low", 32'(tmr8), 32'(i + 1));
        end
        chk("xr_total", 32'(tmr8), 32'h05);

        // ---------------- external falling edges ----------------
        t0se = 1'b1;
        write8(8'h00);
        step(3);
        for (int i = 0; i < 5; i++) begin
            t0cki = 1'b1;
            step(3);
            chk("xf_high", 32'(tmr8), 32'(i));
            t0cki = 1'b0;
            step(1);
            chk("xf_k",  32'(tmr8), 32'(i));
            step(1);
            chk("xf_k1", 32'(tmr8), 32'(i));
            step(1);
            chk("xf_k2", 32'(tmr8), 32'(i + 1));
        end
        chk("xf_total", 32'(tmr8), 32'h05);

        // ---------------- 16-bit instance ----------------
        t0cs = 1'b0; t0se = 1'b0; psa = 1'b1; tmr_en = 1'b1;
        wr_en16 = 1'b1;
        wr_data16 = 16'hFFFD;
        step(1);
        wr_en16 = 1'b0;
        chk("w16_w",  32'(tmr16), 32'hFFFD);
        step(3);
        chk("w16_w3", 32'(tmr16), 32'hFFFE);
        step(1);
        chk("w16_w4", 32'(tmr16), 32'hFFFF);
        chk("w16_w4_if", 32'(if16), 32'h0);
        step(1);
        chk("w16_w5", 32'(tmr16), 32'h0000);
        chk("w16_w5_if", 32'(if16), 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tmr0_ng.md
# tmr0_ng

Parametrised next-generation TMR0 timer/counter for the PIC16F84A-style core. It counts either the core clock or a synchronised external pin, through an optional power-of-two prescaler. It raises a sticky overflow flag on wrap. Beyond the 8-bit TMR0 it adds configurable counter and prescaler width, an enable, a software load with increment inhibit, and a flag clear.

## Interface
Parameters:
- WIDTH, 8, timer counter width in bits (8 or 16 supported)
- PS_BITS, 3, prescaler-select width; prescaler counter is 2**PS_BITS bits

Ports:
- oscIn  in  1  core clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- t0cki  in  1  external count input, asynchronous to oscIn
- t0cs  in  1  source select: 0 = oscIn (one event per cycle), 1 = t0cki edge
- t0se  in  1  external edge select: 0 = rising, 1 = falling
- psa  in  1  1 = prescaler bypassed, 0 = prescaler assigned
- ps  in  PS_BITS  prescale ratio select, ratio R = 2**(ps+1)
- tmr_en  in  1  1 = count; 0 = timer and prescaler frozen
- wr_en  in  1  load strobe for the timer
- wr_data  in  WIDTH  load value
- t0if_clr  in  1  clears t0if
- tmr0out  out  WIDTH  timer value (registered)
- t0if  out  1  sticky overflow flag (registered)

## Operation
- Reset (reset=0, async): tmr0out=0, t0if=0, prescaler=0, sync/history flops=0, inhibit counter=0, ps/psa shadow=0.
- External path: t0cki passes through 2-flop synchroniser s1→s2, plus history flop s3.
  - Event when t0cs=1 and (t0se=0 ? s2&~s3 : ~s2&s3).
  - Sync flops run regardless of tmr_en.
- Internal path: event every cycle when t0cs=0.
- Events are discarded when tmr_en=0 or the inhibit counter is nonzero.
- Prescaler:
  - psa=1: every accepted event increments the timer.
  - psa=0: prescaler counts accepted events. On the event when prescaler==R-1, the prescaler returns to 0 and the timer increments on the same edge.
- Prescaler is cleared on a wr_en edge and on any edge where ps or psa differs from its registered shadow (the shadow updates on that same edge).
- Timer increment is modulo 2**WIDTH. Incrementing from all-ones gives 0 and sets t0if on the same edge.
- Write:
  - wr_en=1 at edge w: tmr0out=wr_data, prescaler=0, inhibit counter=2.
  - Increments are suppressed at edges w+1 and w+2; counting resumes at w+3.
  - Events during inhibit are dropped, not queued.
- Priority on one edge: wr_en over increment. A write of all-ones with a pending event does not set t0if.
- t0if: set on wrap, cleared by t0if_clr. If set and clear occur on the same edge, set wins and t0if=1.
- tmr_en=0 also holds the inhibit counter.

## Timing
- Internal, psa=1: tmr0out increments every oscIn edge.
- External: a t0cki transition stable before edge k is captured in s1 at k and s2 at k+1. The event is asserted after k+1, so tmr0out updates at k+2 (psa=1).
- The t0cki high and low phases must each be at least 2 oscIn cycles. Shorter pulses may be missed; this is legal and needs no flag.
- Prescaled: the first timer increment occurs on the edge consuming the R-th accepted event after a prescaler clear.
- t0if asserts on the same edge that tmr0out goes from all-ones to 0. The flag clears one edge after t0if_clr is sampled.
- No combinational path from any input to any output.

## Test plan
- Reset: hold reset=0 mid-count with tmr0out=0x37 and t0if=1 → tmr0out=0 and t0if=0 immediately, without waiting for a clock edge; both stay 0 until reset=1.
- Internal prescaled: WIDTH=8, t0cs=0, psa=0, ps=1 (R=4), tmr_en=1 → tmr0out steps every 4 cycles; at cycle 1024 after release tmr0out=0x00 and t0if=1.
- Write inhibit: psa=1, wr_data=0xFE at edge w → 0xFE at w, w+1 and w+2; 0xFF at w+3; 0x00 with t0if=1 at w+4.
- External edges: t0cs=1, psa=1, t0se=0, 5 pulses of 3 cycles high / 3 cycles low → tmr0out=5. Repeat with t0se=1 → each count lands 2 edges after the falling transition.
- Flag and enable:
  - t0if_clr on the same edge as a wrap → t0if=1.
  - t0if_clr alone → t0if=0 on the next edge.
  - tmr_en=0 for 10 cycles → tmr0out unchanged and prescaler count preserved.
  - Changing ps mid-count → prescaler restarts from 0.
- Width: WIDTH=16, psa=1, write 0xFFFD at w → 0xFFFF at w+4; 0x0000 with t0if=1 at w+5.
